// File: rtl/innerproduct_seq_ctrl.sv
// Sequential logistic-regression inner product. One shared DW x DW multiplier
// steps through the feature window, and the sum is returned over valid/ready.
module innerproduct_seq_ctrl #(
    parameter int unsigned NFEAT    = 41,
    parameter int unsigned SKIP_IDX = 1,
    parameter int unsigned DW       = 32,
    parameter int unsigned AW       = 6
) (
    input  logic          clk,
    input  logic          reset,
    input  logic          start,
    output logic          busy,
    output logic          rd_en,
    output logic [AW-1:0] rd_addr,
    input  logic [DW-1:0] x_data,
    input  logic [DW-1:0] theta_data,
    output logic [DW-1:0] hprime,
    output logic          out_valid,
    input  logic          out_ready
);
    localparam logic [AW-1:0] LAST_IDX = AW'(NFEAT - 1);
    localparam logic [AW-1:0] SKIP     = AW'(SKIP_IDX);

    typedef enum logic [1:0] {IDLE, RUN, DRAIN, OUT} state_e;

    state_e        state_q;
    logic          busy_q;
    logic          rd_en_q;
    logic [AW-1:0] idx_q;
    logic          out_valid_q;
    logic [DW-1:0] acc_q;

    logic          s1_v_q;
    logic [AW-1:0] s1_idx_q;
    logic          s2_v_q;
    logic [AW-1:0] s2_idx_q;
    logic [DW-1:0] term_q;

    logic [DW-1:0] prod_c;
    logic [DW-1:0] term_c;

    // Index 0 is the bias (theta only); the skip index contributes nothing.
    always_comb begin
        prod_c = x_data * theta_data;
        term_c = prod_c;
        if (s1_idx_q == '0) begin
            term_c = theta_data;
        end else if (s1_idx_q == SKIP) begin
            term_c = '0;
        end
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state_q     <= IDLE;
            busy_q      <= 1'b0;
            rd_en_q     <= 1'b0;
            idx_q       <= '0;
            out_valid_q <= 1'b0;
            acc_q       <= '0;
            s1_v_q      <= 1'b0;
            s1_idx_q    <= '0;
            s2_v_q      <= 1'b0;
            s2_idx_q    <= '0;
            term_q      <= '0;
        end else begin
            s1_v_q   <= rd_en_q;
            s1_idx_q <= idx_q;
            s2_v_q   <= s1_v_q;
            s2_idx_q <= s1_idx_q;
            term_q   <= term_c;
            if (s2_v_q) begin
                acc_q <= acc_q + term_q;
            end

            case (state_q)
                IDLE: begin
                    if (start) begin
                        state_q <= RUN;
                        busy_q  <= 1'b1;
                        rd_en_q <= 1'b1;
                        idx_q   <= '0;
                        acc_q   <= '0;
                    end
                end
                RUN: begin
                    if (idx_q == LAST_IDX) begin
                        rd_en_q <= 1'b0;
                        state_q <= DRAIN;
                    end else begin
                        idx_q <= idx_q + AW'(1);
                    end
                end
                // The edge that folds in the last term also raises out_valid.
                DRAIN: begin
                    if (s2_v_q && (s2_idx_q == LAST_IDX)) begin
                        out_valid_q <= 1'b1;
                        state_q     <= OUT;
                    end
                end
                OUT: begin
                    if (out_ready) begin
                        out_valid_q <= 1'b0;
                        busy_q      <= 1'b0;
                        state_q     <= IDLE;
                    end
                end
                default: state_q <= IDLE;
            endcase
        end
    end

    assign busy      = busy_q;
    assign rd_en     = rd_en_q;
    assign rd_addr   = idx_q;
    assign out_valid = out_valid_q;
    assign hprime    = acc_q;
endmodule
